// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding controller for a 5-stage pipeline; HAZARD_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MAX_WAIT    = 16,
  parameter int REG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
`ifdef HAZARD_PERF_EN
  output logic [31:0]      PerfStallCnt,
  output logic [31:0]      PerfFlushCnt,
`endif
  output logic             Fault
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [2:0] {S_INIT, S_RUN, S_LDSTALL, S_MEMWAIT, S_FAULT} state_t;
  state_t          r_state, w_next;
  logic [IW-1:0]   r_init_cnt;
  logic [WW-1:0]   r_wait_cnt;
  logic            w_init, w_fault, w_active, w_freeze, w_lw, w_wait_lim, w_init_last;
  logic [1:0]      w_fwd_a, w_fwd_b;
  assign w_init      = r_state == S_INIT;
  assign w_fault     = r_state == S_FAULT;
  assign w_active    = !w_init && !w_fault;
  assign w_freeze    = MemReqM && !MemReadyM;
  assign w_lw        = ResultSrcE0 && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign w_wait_lim  = r_wait_cnt == WW'(MAX_WAIT - 1);
  assign w_init_last = r_init_cnt == IW'(INIT_CYCLES - 1);
  assign w_fwd_a = (RegWriteM && RdM != '0 && RdM == Rs1E) ? 2'b10 :
                   (RegWriteW && RdW != '0 && RdW == Rs1E) ? 2'b01 : 2'b00;
  assign w_fwd_b = (RegWriteM && RdM != '0 && RdM == Rs2E) ? 2'b10 :
                   (RegWriteW && RdW != '0 && RdW == Rs2E) ? 2'b01 : 2'b00;
  // state register plus init-sequence and memory-wait counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_init_cnt <= w_init ? r_init_cnt + 1'b1 : '0;
      r_wait_cnt <= (w_active && w_freeze) ? r_wait_cnt + 1'b1 : '0;
    end
  end
  // next state: memory freeze dominates, a redirect cancels the load-use bubble
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  w_next = w_init_last ? S_RUN : S_INIT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = w_freeze ? (w_wait_lim ? S_FAULT : S_MEMWAIT) :
                        (r_state != S_LDSTALL && w_lw && !PCSrcE) ? S_LDSTALL : S_RUN;
    endcase
  end
  // Mealy control outputs from state and current hazards
  always_comb begin
    StallF    = w_init || w_fault || (w_active && (w_freeze || (w_lw && !PCSrcE)));
    StallD    = w_fault || (w_active && (w_freeze || (w_lw && !PCSrcE)));
    StallE    = w_fault || (w_active && w_freeze);
    StallM    = w_fault || (w_active && w_freeze);
    FlushD    = w_init || (w_active && !w_freeze && PCSrcE);
    FlushE    = w_init || (w_active && !w_freeze && (PCSrcE || w_lw));
    ForwardAE = w_init ? 2'b00 : w_fwd_a;
    ForwardBE = w_init ? 2'b00 : w_fwd_b;
    Fault     = w_fault;
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall, r_perf_flush;
  // saturating counts of decode stalls and execute flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_active && StallD && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      if (!w_init && FlushE && r_perf_flush != '1) r_perf_flush <= r_perf_flush + 1'b1;
    end
  end
  assign PerfStallCnt = r_perf_stall;
  assign PerfFlushCnt = r_perf_flush;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-level reference model of the hazard controller
module tb_pipe_hazard_ctrl;
  localparam int INIT_CYCLES = 4;
  localparam int MAX_WAIT    = 16;
  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       rwm, rww, ld, pcs, req, rdy;
  } in_t;
  typedef struct {
    logic [10:0] ctl;
    logic [31:0] ps, pf;
    int          cyc;
  } exp_t;
  logic clk = 0;
  in_t  v_in;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, Fault;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] PerfStallCnt, PerfFlushCnt;
  int errors = 0, checks = 0, cyc = 0;
  exp_t q[$];
  int m_init, m_waits;
  bit m_fault;
  logic [31:0] m_ps, m_pf;
  in_t m_cur;
  logic [10:0] m_exp;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MAX_WAIT(MAX_WAIT), .REG_W(5)) dut (
    .clk(clk), .rst_n(v_in.rst_n),
    .Rs1D(v_in.rs1d), .Rs2D(v_in.rs2d), .Rs1E(v_in.rs1e), .Rs2E(v_in.rs2e),
    .RdE(v_in.rde), .RdM(v_in.rdm), .RdW(v_in.rdw),
    .RegWriteM(v_in.rwm), .RegWriteW(v_in.rww), .ResultSrcE0(v_in.ld), .PCSrcE(v_in.pcs),
    .MemReqM(v_in.req), .MemReadyM(v_in.rdy),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt(PerfStallCnt), .PerfFlushCnt(PerfFlushCnt),
`endif
    .Fault(Fault)
  );
`ifndef HAZARD_PERF_EN
  assign PerfStallCnt = '0;
  assign PerfFlushCnt = '0;
`endif
  function automatic logic [1:0] fwd(in_t v, logic [4:0] rs);
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction
  // expected {StallF,StallD,StallE,StallM,FlushD,FlushE,ForwardAE,ForwardBE,Fault}
  function automatic logic [10:0] expect_ctl(in_t v);
    logic lw;
    logic [1:0] fa, fb;
    if (m_init > 0) return {4'b1000, 2'b11, 4'b0000, 1'b0};
    fa = fwd(v, v.rs1e);
    fb = fwd(v, v.rs2e);
    if (m_fault) return {4'b1111, 2'b00, fa, fb, 1'b1};
    if (v.req && !v.rdy) return {4'b1111, 2'b00, fa, fb, 1'b0};
    lw = v.ld && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d);
    return {lw && !v.pcs, lw && !v.pcs, 2'b00, v.pcs, v.pcs || lw, fa, fb, 1'b0};
  endfunction
  task automatic model_reset();
    m_init = INIT_CYCLES; m_waits = 0; m_fault = 0; m_ps = 0; m_pf = 0;
  endtask
  // advance the model across one clock edge using the inputs of the cycle that just ended
  task automatic model_edge();
    if (!m_cur.rst_n) begin
      model_reset();
      return;
    end
    if (m_init == 0 && !m_fault && m_exp[9] && m_ps != '1) m_ps++;
    if (m_init == 0 && m_exp[5] && m_pf != '1) m_pf++;
    if (m_init > 0) m_init--;
    else if (!m_fault && m_cur.req && !m_cur.rdy) begin
      m_waits++;
      if (m_waits >= MAX_WAIT) m_fault = 1;
    end else if (!m_fault) m_waits = 0;
  endtask
  task automatic go(in_t v);
    exp_t e;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    v_in = v;
    m_cur = v;
    if (!v.rst_n) model_reset();
    m_exp = expect_ctl(v);
    e.ctl = m_exp; e.ps = m_ps; e.pf = m_pf; e.cyc = cyc;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] got;
      e = q.pop_front();
      got = {StallF, StallD, StallE, StallM, FlushD, FlushE, ForwardAE, ForwardBE, Fault};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctl);
      end
`ifdef HAZARD_PERF_EN
      checks++;
      if (PerfStallCnt !== e.ps || PerfFlushCnt !== e.pf) begin
        errors++;
        $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", e.cyc, PerfStallCnt, PerfFlushCnt, e.ps, e.pf);
      end
`endif
    end
  end
  in_t idle, v;
  initial begin
    idle = '0;
    idle.rst_n = 1;
    v = idle;
    v.rst_n = 0;
    v_in = v;
    m_cur = v;
    model_reset();
    repeat (2) go(v);
    for (int i = 0; i < 6; i++) go(idle);
    v = idle; v.ld = 1; v.rde = 5; v.rs1d = 5; go(v);
    v = idle; v.rdm = 5; v.rwm = 1; v.rs1e = 5; go(v);
    go(idle);
    v = idle; v.rdm = 7; v.rdw = 7; v.rwm = 1; v.rww = 1; v.rs2e = 7; go(v);
    v.rdm = 0; v.rdw = 0; go(v);
    v = idle; v.rdw = 3; v.rww = 1; v.rs1e = 3; v.rs2e = 3; go(v);
    v = idle; v.pcs = 1; v.ld = 1; v.rde = 9; v.rs2d = 9; go(v);
    go(idle);
    v = idle; v.req = 1;
    repeat (3) go(v);
    v.rdy = 1; go(v);
    repeat (2) go(idle);
    v = idle; v.req = 1; v.rdy = 0;
    repeat (MAX_WAIT - 1) go(v);
    v.rdy = 1; go(v);
    go(idle);
    v.rdy = 0;
    repeat (MAX_WAIT) go(v);
    repeat (3) go(idle);
    v = idle; v.req = 1;
    repeat (5) go(v);
    v.rst_n = 0; go(v);
    repeat (INIT_CYCLES + 2) go(idle);
    v = idle; v.ld = 1; v.rde = 2; v.rs2d = 2; go(v);
    go(idle);
    v = idle; v.pcs = 1; go(v);
    repeat (2) go(idle);
    for (int i = 0; i < 3000; i++) begin
      v.rst_n = ($urandom_range(0, 199) != 0);
      v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
      v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
      v.rde = 5'($urandom_range(0, 3)); v.rdm = 5'($urandom_range(0, 3)); v.rdw = 5'($urandom_range(0, 3));
      v.rwm = 1'($urandom_range(0, 1)); v.rww = 1'($urandom_range(0, 1));
      v.ld = ($urandom_range(0, 9) < 3); v.pcs = ($urandom_range(0, 9) < 2);
      v.req = ($urandom_range(0, 9) < 4);
      v.rdy = (i % 500 > 460) ? 1'b0 : ($urandom_range(0, 9) < 6);
      go(v);
    end
    go(idle);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
